// File: rtl/pdm_cic_decimator_pkg.sv
// Shared constants, width helpers and word types for the mic-array front end.
// Helpers derive CIC internal width and output shift from the module parameters.
package mic_array_pkg;

    localparam int PCM_W         = 8;
    localparam int NUM_MICS_DEF  = 25;
    localparam int CLK_DIV_DEF   = 32;
    localparam int DECIM_DEF     = 64;
    localparam int CIC_ORDER_DEF = 4;

    // Full-scale gain is DECIM^ORDER; two guard bits hold the signed +/- swing.
    function automatic int cic_width(int order, int decim);
        return 2 + order * $clog2(decim);
    endfunction

    function automatic int cic_shift(int order, int decim, int bw);
        return order * $clog2(decim) + 1 - bw;
    endfunction

    localparam int CIC_W     = cic_width(CIC_ORDER_DEF, DECIM_DEF);
    localparam int CIC_SHIFT = cic_shift(CIC_ORDER_DEF, DECIM_DEF, PCM_W);

    typedef logic signed [CIC_W-1:0] cic_acc_t;
    typedef logic [PCM_W-1:0]        pcm_t;

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// PDM in / PCM out bundle between the mics, the decimator and the beamformer.
interface pdm_cic_decimator_if #(
    parameter int NUM_MICS  = 25,
    parameter int BIT_WIDTH = 8
);
    logic [NUM_MICS-1:0]  pdm_data_in;
    logic                 pdm_clk;
    logic [BIT_WIDTH-1:0] pcm_data_out [0:NUM_MICS-1];
    logic                 pcm_valid;

    modport master (input pdm_data_in, output pdm_clk, output pcm_data_out, output pcm_valid);
    modport slave  (output pdm_data_in, input pdm_clk, input pcm_data_out, input pcm_valid);
endinterface

// File: rtl/pdm_cic_decimator_channel.sv
// One mic's CIC datapath: integrators, combs, scale and clip to a PCM word.
// Macro PCM_OFFSET_BINARY_EN selects offset-binary output instead of two's complement.
module cic_channel
    import mic_array_pkg::*;
#(
    parameter int BIT_WIDTH = PCM_W,
    parameter int DECIM     = DECIM_DEF,
    parameter int CIC_ORDER = CIC_ORDER_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_stb,
    input  logic                 comb_stb,
    input  logic                 pdm_bit,
    output logic [BIT_WIDTH-1:0] pcm_out
);
    localparam int W     = cic_width(CIC_ORDER, DECIM);
    localparam int SHIFT = cic_shift(CIC_ORDER, DECIM, BIT_WIDTH);
    localparam int SHR   = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHL   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int SW    = W + SHL;

    typedef logic signed [W-1:0]  acc_t;
    typedef logic signed [SW-1:0] scl_t;

    localparam scl_t PCM_MAX = scl_t'((1 << (BIT_WIDTH - 1)) - 1);
    localparam scl_t PCM_MIN = -PCM_MAX - scl_t'(1);
`ifdef PCM_OFFSET_BINARY_EN
    localparam logic [BIT_WIDTH-1:0] MSB_FLIP = {1'b1, {(BIT_WIDTH-1){1'b0}}};
`else
    localparam logic [BIT_WIDTH-1:0] MSB_FLIP = '0;
`endif

    acc_t                 integ_q [CIC_ORDER];
    acc_t                 integ_d [CIC_ORDER];
    acc_t                 dly_q   [CIC_ORDER];
    acc_t                 dly_d   [CIC_ORDER];
    acc_t                 stage   [CIC_ORDER+1];
    acc_t                 x;
    scl_t                 scaled;
    logic [BIT_WIDTH-1:0] clipped;
    logic [BIT_WIDTH-1:0] pcm_q, pcm_d;

    always_comb begin
        integ_d = integ_q;
        dly_d   = dly_q;
        pcm_d   = pcm_q;
        x       = pdm_bit ? acc_t'(1) : acc_t'(-1);
        // Each stage adds the previous registered value; wrap-around is harmless in a CIC.
        if (sample_stb) begin
            integ_d[0] = integ_q[0] + x;
            for (int k = 1; k < CIC_ORDER; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
        end
        stage[0] = integ_q[CIC_ORDER-1];
        for (int k = 0; k < CIC_ORDER; k++) stage[k+1] = stage[k] - dly_q[k];
        scaled = (scl_t'(stage[CIC_ORDER]) >>> SHR) <<< SHL;
        if (scaled > PCM_MAX)      clipped = {1'b0, {(BIT_WIDTH-1){1'b1}}};
        else if (scaled < PCM_MIN) clipped = {1'b1, {(BIT_WIDTH-1){1'b0}}};
        else                       clipped = scaled[BIT_WIDTH-1:0];
        if (comb_stb) begin
            for (int k = 0; k < CIC_ORDER; k++) dly_d[k] = stage[k];
            pcm_d = clipped ^ MSB_FLIP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            pcm_q <= MSB_FLIP;
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
            pcm_q   <= pcm_d;
        end
    end

    assign pcm_out = pcm_q;

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM bit-clock generator, input synchronizers, decimation timing and per-mic CIC array.
// Macro PCM_OFFSET_BINARY_EN (in cic_channel) switches PCM words to offset binary.
module pdm_cic_decimator
    import mic_array_pkg::*;
#(
    parameter int BIT_WIDTH = PCM_W,
    parameter int NUM_MICS  = NUM_MICS_DEF,
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int DECIM     = DECIM_DEF,
    parameter int CIC_ORDER = CIC_ORDER_DEF
) (
    input logic                 clk,
    input logic                 rst,
    pdm_cic_decimator_if.master bus
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int DEC_W = $clog2(DECIM);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pdm_clk_q, pdm_clk_d;
    logic [NUM_MICS-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DEC_W-1:0]     dec_q, dec_d;
    logic                 comb_stb_q, comb_stb_d;
    logic                 pcm_valid_q, pcm_valid_d;
    logic                 sample_stb;
    logic [BIT_WIDTH-1:0] pcm_w [0:NUM_MICS-1];

    always_comb begin
        cnt_d       = (cnt_q == CNT_W'(CLK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        // Registered from the next count so pdm_clk is a clean flop output aligned to cnt_q.
        pdm_clk_d   = (cnt_d < CNT_W'(CLK_DIV / 2));
        sample_stb  = (cnt_q == CNT_W'(CLK_DIV - 1));
        sync1_d     = bus.pdm_data_in;
        sync2_d     = sync1_q;
        dec_d       = dec_q;
        comb_stb_d  = 1'b0;
        if (sample_stb) begin
            dec_d      = dec_q + DEC_W'(1);
            comb_stb_d = (dec_q == '1);
        end
        pcm_valid_d = comb_stb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            pdm_clk_q   <= 1'b1;
            sync1_q     <= '0;
            sync2_q     <= '0;
            dec_q       <= '0;
            comb_stb_q  <= 1'b0;
            pcm_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pdm_clk_q   <= pdm_clk_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dec_q       <= dec_d;
            comb_stb_q  <= comb_stb_d;
            pcm_valid_q <= pcm_valid_d;
        end
    end

    for (genvar g = 0; g < NUM_MICS; g++) begin : g_ch
        cic_channel #(
            .BIT_WIDTH (BIT_WIDTH),
            .DECIM     (DECIM),
            .CIC_ORDER (CIC_ORDER)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sample_stb (sample_stb),
            .comb_stb   (comb_stb_q),
            .pdm_bit    (sync2_q[g]),
            .pcm_out    (pcm_w[g])
        );
    end

    assign bus.pdm_clk      = pdm_clk_q;
    assign bus.pcm_valid    = pcm_valid_q;
    assign bus.pcm_data_out = pcm_w;

endmodule
